// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin, burst-bounded sharing of one data memory port between two masters.
module data_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [1:0]        m0_we,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [1:0]        m1_we,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] MB = CW'(MAX_BURST);
  typedef enum logic [1:0] {NONE, M0, M1} mst_t;
  mst_t owner, last, win;
  logic [CW-1:0] burst_cnt;
  logic [1:0] we0_e, we1_e;
  logic rd;
  assign we0_e = m0_we == 2'b01 ? 2'b00 : m0_we;
  assign we1_e = m1_we == 2'b01 ? 2'b00 : m1_we;
  always_comb begin
    win = NONE;
    if (!rst)
      win = (m0_req && m1_req) ?
              (owner == NONE ? (last == M0 ? M1 : M0) :
               burst_cnt < MB ? owner : (owner == M0 ? M1 : M0)) :
            m0_req ? M0 : m1_req ? M1 : NONE;
  end
  assign m0_gnt    = win == M0;
  assign m1_gnt    = win == M1;
  assign mem_addr  = m0_gnt ? m0_addr : m1_gnt ? m1_addr : '0;
  assign mem_wdata = m0_gnt ? m0_wdata : m1_gnt ? m1_wdata : '0;
  assign mem_we    = m0_gnt ? we0_e : m1_gnt ? we1_e : 2'b00;
  assign rd        = win != NONE && mem_we == 2'b00;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= NONE;
      last      <= M1;
      burst_cnt <= '0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      owner     <= win;
      burst_cnt <= win == NONE ? '0 : win != owner ? CW'(1) :
                   burst_cnt == MB ? MB : burst_cnt + 1'b1;
      if (win != NONE) last <= win;
      m0_rvalid <= m0_gnt && rd;
      m1_rvalid <= m1_gnt && rd;
      if (m0_gnt && rd) m0_rdata <= mem_rdata;
      if (m1_gnt && rd) m1_rdata <= mem_rdata;
    end
  end
endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single write/primary-read port of the data memory between two requesters: m0 (CPU load/store stage) and m1 (loader/DMA engine).
- Grants at most one access per cycle.
- Grant selection is round-robin with a bounded burst, so neither master is starved.
- Forwards address, data and MemWrite code to the memory, and returns registered read data to the granted master.

Parameters:
- ADDR_W, 32, address width of both masters and the memory port.
- DATA_W, 32, data width.
- MAX_BURST, 4, max consecutive grants to one master while the other is requesting (>=1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  m0 access request; held with its address/data/code until granted.
- m0_addr  in  ADDR_W  m0 address.
- m0_wdata  in  DATA_W  m0 write data.
- m0_we  in  2  m0 MemWrite code: 00 read, 10 word write, 11 byte write, 01 reserved.
- m0_gnt  out  1  m0 access performed this cycle.
- m0_rvalid  out  1  m0 read data valid (one cycle after a granted read).
- m0_rdata  out  DATA_W  m0 read data.
- m1_req, m1_addr, m1_wdata, m1_we, m1_gnt, m1_rvalid, m1_rdata: same as m0, for m1.
- mem_addr  out  ADDR_W  to memory Address.
- mem_wdata  out  DATA_W  to memory Write_data.
- mem_we  out  2  to memory MemWrite.
- mem_rdata  in  DATA_W  from memory Read_data (combinational read of mem_addr).

Behaviour:

State registers:
- owner: NONE / M0 / M1.
- last: last master served.
- burst_cnt: width clog2(MAX_BURST)+1.
- Per master: rvalid and rdata registers.

Reset (async, rst=1):
- owner=NONE, last=M1 (so m0 wins the first tie), burst_cnt=0.
- All rvalid=0, all rdata=0.
- gnt outputs forced 0, mem_we forced 00, mem_addr=0, mem_wdata=0.
- Pending read results are discarded. Masters re-request after reset.

Winner selection (combinational, evaluated each cycle):
- No req asserted: winner NONE.
- Only one req asserted: that master wins.
- Both req asserted, owner is NONE: the master that is not `last` wins.
- Both req asserted, owner is Mx:
  - Mx keeps the grant while burst_cnt < MAX_BURST.
  - Otherwise the other master wins.

Grant and memory drive:
- gnt of the winner is asserted in the same cycle (combinational); the access completes that cycle.
- mem_addr, mem_wdata and mem_we are driven from the winner.
- Code 01 is forwarded as 00 (treated as read, no write).
- With no winner: mem_we=00, mem_addr=0, mem_wdata=0.

Registered updates on clock edge:
- owner <= winner.
- If winner differs from the previous owner or is NONE: burst_cnt <= 1 (0 if NONE).
- Else burst_cnt <= burst_cnt+1, saturating at MAX_BURST.
- When winner is not NONE: last <= winner.

Read return:
- For a granted access with effective code 00, the winner's rdata <= mem_rdata and its rvalid <= 1 at the next edge.
- rvalid is a one-cycle pulse per granted read.
- rdata holds its value until the next granted read of that master.
- Writes produce no rvalid.
- Back-to-back reads give back-to-back rvalid pulses.

Boundary conditions:
- A master dropping req without being granted is legal; no side effects.
- An owner that deasserts req releases the resource immediately; the other master can win in the same cycle.
- With MAX_BURST=1 the arbiter alternates strictly under contention.
- A master continuously requesting alone is granted every cycle; burst_cnt saturates and causes no switch.

Test Plan:
- After reset, m0 read addr 0x0 only -> m0_gnt=1 same cycle, mem_we=00, mem_addr=0; next cycle m0_rvalid=1 and m0_rdata equals memory word at 0x0.
- m1 word write addr 0x5, data 0x58, code 10 -> mem_we=10, mem_addr=5, mem_wdata=0x58, m1_gnt=1; a following m1 read of 0x5 gives m1_rdata=0x58 one cycle later.
- Both request continuously, MAX_BURST=4, starting from reset -> grant sequence m0,m0,m0,m0,m1,m1,m1,m1,m0...; no master waits more than 4 cycles.
- Both request in the same first cycle after idle, with last=M0 -> m1 granted; m0 granted the next cycle once m1 drops req.
- m0 issues code 01 at addr 0x2 -> mem_we=00, m0_gnt=1, m0_rvalid=1 next cycle; memory contents unchanged.
- rst asserted the cycle after a granted m0 read -> m0_rvalid stays 0, owner=NONE, all gnt=0, mem_we=00 while rst=1; the first grant after release goes to m0 under a tie.
